// File: rtl/ahb3lite_irq_gen_if.sv
// AHB3-lite slave bus bundle for the interrupt generator.
interface ahb3lite_irq_gen_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_irq_gen.sv
// AHB3-lite interrupt generator: level/edge interrupt sources with enable mask.
// Define IRQ_GEN_SYNC_EN to insert a two-flop synchroniser on EXT_IRQ.
module ahb3lite_irq_gen #(
  parameter int unsigned NUM_IRQ = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  ahb3lite_irq_gen_if.slave  ahb,
  input  logic [NUM_IRQ-1:0] EXT_IRQ,
  output logic [NUM_IRQ-1:0] IRQ
);

  localparam logic [2:0] OFF_LEVEL    = 3'd0;
  localparam logic [2:0] OFF_EDGE_SET = 3'd1;
  localparam logic [2:0] OFF_EDGE_LOG = 3'd2;
  localparam logic [2:0] OFF_ENABLE   = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    ERR1,
    ERR2
  } state_t;

  state_t state_q, state_d;

  logic       dvalid_q, dvalid_d;
  logic       dwrite_q, dwrite_d;
  logic [2:0] daddr_q,  daddr_d;

  logic [NUM_IRQ-1:0] level_q,  level_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] log_q,    log_d;
  logic [NUM_IRQ-1:0] irq_q,    irq_d;
  logic [NUM_IRQ-1:0] s_d_q;
  logic [NUM_IRQ-1:0] rising_q;
  logic [NUM_IRQ-1:0] s;

  logic               accept;
  logic               bad_access;
  logic               wr_en;
  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [NUM_IRQ-1:0] edge_pulse;
  logic [31:0]        rdata;

  logic unused_ahb;
  assign unused_ahb = ^{ahb.HADDR[31:5], ahb.HADDR[1:0], ahb.HBURST, ahb.HPROT};

  // ---------------------------------------------------------------------------
  // Address phase decode and response FSM
  // ---------------------------------------------------------------------------
  assign accept     = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign bad_access = (ahb.HADDR[4:2] > OFF_STATUS) |
                      (ahb.HSIZE != 3'b010) |
                      (ahb.HWRITE & (ahb.HADDR[4:2] == OFF_STATUS));

  always_comb begin
    state_d  = state_q;
    dvalid_d = 1'b0;
    dwrite_d = dwrite_q;
    daddr_d  = daddr_q;
    unique case (state_q)
      IDLE, ERR2: begin
        state_d = IDLE;
        if (accept) begin
          if (bad_access) begin
            state_d = ERR1;
          end else begin
            dvalid_d = 1'b1;
            dwrite_d = ahb.HWRITE;
            daddr_d  = ahb.HADDR[4:2];
          end
        end
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      dvalid_q <= 1'b0;
      dwrite_q <= 1'b0;
      daddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      dvalid_q <= dvalid_d;
      dwrite_q <= dwrite_d;
      daddr_q  <= daddr_d;
    end
  end

  assign ahb.HREADYOUT = RESET | (state_q != ERR1);
  assign ahb.HRESP     = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // External edge detection
  // ---------------------------------------------------------------------------
`ifdef IRQ_GEN_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q;
  logic [NUM_IRQ-1:0] sync2_q;

  // Reset preloads the live input so lines already high do not look like edges.
  always_ff @(posedge CLK) begin
    sync1_q <= EXT_IRQ;
    sync2_q <= RESET ? EXT_IRQ : sync1_q;
  end

  assign s = sync2_q;
`else
  assign s = EXT_IRQ;
`endif

  always_ff @(posedge CLK) begin
    s_d_q <= s;
    if (RESET) begin
      rising_q <= '0;
    end else begin
      rising_q <= s & ~s_d_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file and interrupt output
  // ---------------------------------------------------------------------------
  assign wr_en = dvalid_q & dwrite_q;

  always_comb begin
    level_d  = level_q;
    enable_d = enable_q;
    set_vec  = '0;
    clr_vec  = '0;
    if (wr_en) begin
      unique case (daddr_q)
        OFF_LEVEL:    level_d  = ahb.HWDATA;
        OFF_EDGE_SET: set_vec  = ahb.HWDATA;
        OFF_EDGE_LOG: clr_vec  = ahb.HWDATA;
        OFF_ENABLE:   enable_d = ahb.HWDATA;
        default:      ;
      endcase
    end
    edge_pulse = rising_q | set_vec;
    log_d      = (log_q & ~clr_vec) | edge_pulse;
    // Next-state LEVEL/ENABLE so a register write reaches IRQ one cycle after its data phase.
    irq_d      = (level_d | edge_pulse) & enable_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      level_q  <= '0;
      enable_q <= '0;
      log_q    <= '0;
      irq_q    <= '0;
    end else begin
      level_q  <= level_d;
      enable_q <= enable_d;
      log_q    <= log_d;
      irq_q    <= irq_d;
    end
  end

  assign IRQ = irq_q;

  // ---------------------------------------------------------------------------
  // Read data, valid only during a read data phase
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    if (dvalid_q && !dwrite_q) begin
      unique case (daddr_q)
        OFF_LEVEL:    rdata = level_q;
        OFF_EDGE_LOG: rdata = log_q;
        OFF_ENABLE:   rdata = enable_q;
        OFF_STATUS:   rdata = irq_q;
        default:      rdata = '0;
      endcase
    end
  end

  assign ahb.HRDATA = rdata;

endmodule

// File: tb/tb_ahb3lite_irq_gen.sv
// Directed self-checking bench for ahb3lite_irq_gen.
module tb_ahb3lite_irq_gen;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] EXT_IRQ;
  logic [31:0] IRQ;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef IRQ_GEN_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  ahb3lite_irq_gen_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb3lite_irq_gen #(.NUM_IRQ(32)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ahb     (bus.slave),
    .EXT_IRQ (EXT_IRQ),
    .IRQ     (IRQ)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HADDR  = '0;
    bus.HWDATA = '0;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'b010;
    bus.HBURST = 3'b000;
    bus.HPROT  = 4'b0011;
    bus.HTRANS = 2'b00;
  endtask

  // Address phase now; returns at the data-phase sampling point.
  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = addr;
    bus.HWRITE = 1'b1;
    bus.HSIZE  = size;
    @(negedge CLK);
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'b010;
    bus.HWDATA = data;
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic resp, output logic rdy);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = addr;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'b010;
    @(negedge CLK);
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    data = bus.HRDATA;
    resp = bus.HRESP;
    rdy  = bus.HREADYOUT;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        rs, ry;
    RESET   = 1'b1;
    EXT_IRQ = '0;
    bus_idle();
    @(negedge CLK);
    @(negedge CLK);
    ahb_write(32'h0, 32'hFFFF_FFFF, 3'b010);
    @(negedge CLK);
    tests_run++; if (IRQ !== 32'h0) begin tests_failed++; $display("FAIL reset_irq: got %h exp %h", IRQ, 32'h0); end
    tests_run++; if (bus.HREADYOUT !== 1'b1) begin tests_failed++; $display("FAIL reset_hreadyout: got %b exp 1", bus.HREADYOUT); end
    tests_run++; if (bus.HRESP !== 1'b0) begin tests_failed++; $display("FAIL reset_hresp: got %b exp 0", bus.HRESP); end
    tests_run++; if (bus.HRDATA !== 32'h0) begin tests_failed++; $display("FAIL reset_hrdata: got %h exp 0", bus.HRDATA); end
    RESET = 1'b0;
    ahb_read(32'h0, rd, rs, ry);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_level_ignored_write: got %h exp %h", rd, 32'h0); end
    @(negedge CLK);
    ahb_read(32'h8, rd, rs, ry);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_edge_log: got %h exp %h", rd, 32'h0); end
    @(negedge CLK);
    ahb_read(32'hC, rd, rs, ry);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_enable: got %h exp %h", rd, 32'h0); end
    @(negedge CLK);
  endtask

  task automatic test_level();
    logic [31:0] rd;
    logic        rs, ry;
    ahb_write(32'hC, 32'hFFFF_FFFF, 3'b010);
    ahb_write(32'h0, 32'h0000_0005, 3'b010);
    tests_run++; if (IRQ !== 32'h0) begin tests_failed++; $display("FAIL level_irq_data_phase: got %h exp %h", IRQ, 32'h0); end
    @(negedge CLK);
    tests_run++; if (IRQ !== 32'h5) begin tests_failed++; $display("FAIL level_irq: got %h exp %h", IRQ, 32'h5); end
    ahb_read(32'h10, rd, rs, ry);
    tests_run++; if (rd !== 32'h5) begin tests_failed++; $display("FAIL level_status_read: got %h exp %h", rd, 32'h5); end
    tests_run++; if (rs !== 1'b0 || ry !== 1'b1) begin tests_failed++; $display("FAIL level_okay_resp: got resp=%b rdy=%b exp resp=0 rdy=1", rs, ry); end
    @(negedge CLK);
    ahb_read(32'h0, rd, rs, ry);
    tests_run++; if (rd !== 32'h5) begin tests_failed++; $display("FAIL level_readback: got %h exp %h", rd, 32'h5); end
    @(negedge CLK);
    ahb_write(32'h0, 32'h0, 3'b010);
    @(negedge CLK);
    tests_run++; if (IRQ !== 32'h0) begin tests_failed++; $display("FAIL level_clear_irq: got %h exp %h", IRQ, 32'h0); end
  endtask

  task automatic test_edge_set();
    logic [31:0] rd;
    logic        rs, ry;
    ahb_write(32'hC, 32'h1, 3'b010);
    ahb_write(32'h4, 32'h1, 3'b010);
    tests_run++; if (IRQ !== 32'h0) begin tests_failed++; $display("FAIL edge_set_before: got %h exp %h", IRQ, 32'h0); end
    @(negedge CLK);
    tests_run++; if (IRQ !== 32'h1) begin tests_failed++; $display("FAIL edge_set_pulse: got %h exp %h", IRQ, 32'h1); end
    @(negedge CLK);
    tests_run++; if (IRQ !== 32'h0) begin tests_failed++; $display("FAIL edge_set_pulse_end: got %h exp %h", IRQ, 32'h0); end
    ahb_read(32'h8, rd, rs, ry);
    tests_run++; if (rd !== 32'h1) begin tests_failed++; $display("FAIL edge_log_set: got %h exp %h", rd, 32'h1); end
    @(negedge CLK);
    ahb_read(32'h4, rd, rs, ry);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL edge_set_read_zero: got %h exp %h", rd, 32'h0); end
    @(negedge CLK);
    ahb_write(32'h8, 32'h1, 3'b010);
    @(negedge CLK);
    ahb_read(32'h8, rd, rs, ry);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL edge_log_w1c: got %h exp %h", rd, 32'h0); end
    @(negedge CLK);
  endtask

  task automatic test_masked_edge();
    logic [31:0] rd;
    logic        rs, ry;
    ahb_write(32'hC, 32'h0, 3'b010);
    ahb_write(32'h4, 32'h20, 3'b010);
    @(negedge CLK);
    tests_run++; if (IRQ !== 32'h0) begin tests_failed++; $display("FAIL masked_no_pulse: got %h exp %h", IRQ, 32'h0); end
    ahb_read(32'h8, rd, rs, ry);
    tests_run++; if (rd !== 32'h20) begin tests_failed++; $display("FAIL masked_log_set: got %h exp %h", rd, 32'h20); end
    @(negedge CLK);
    ahb_write(32'hC, 32'h20, 3'b010);
    @(negedge CLK);
    @(negedge CLK);
    tests_run++; if (IRQ !== 32'h0) begin tests_failed++; $display("FAIL masked_no_replay: got %h exp %h", IRQ, 32'h0); end
    ahb_write(32'h8, 32'hFFFF_FFFF, 3'b010);
    @(negedge CLK);
  endtask

  task automatic test_ext_edge();
    logic [31:0] rd;
    logic [31:0] exp;
    logic        rs, ry;
    ahb_write(32'hC, 32'h8000_0000, 3'b010);
    @(negedge CLK);
    EXT_IRQ[31] = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge CLK);
      exp = (k == LAT) ? 32'h8000_0000 : 32'h0;
      tests_run++; if (IRQ !== exp) begin tests_failed++; $display("FAIL ext_edge_cycle%0d: got %h exp %h", k, IRQ, exp); end
    end
    EXT_IRQ[31] = 1'b0;
    repeat (LAT + 1) @(negedge CLK);
    ahb_read(32'h8, rd, rs, ry);
    tests_run++; if (rd !== 32'h8000_0000) begin tests_failed++; $display("FAIL ext_edge_log: got %h exp %h", rd, 32'h8000_0000); end
    @(negedge CLK);
    ahb_write(32'h8, 32'hFFFF_FFFF, 3'b010);
    @(negedge CLK);
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    logic        rs, ry;
    EXT_IRQ[3] = 1'b1;
    repeat (LAT - 2) @(negedge CLK);
    ahb_write(32'h8, 32'h8, 3'b010);
    @(negedge CLK);
    ahb_read(32'h8, rd, rs, ry);
    tests_run++; if (rd !== 32'h8) begin tests_failed++; $display("FAIL collision_set_wins: got %h exp %h", rd, 32'h8); end
    @(negedge CLK);
    EXT_IRQ[3] = 1'b0;
    ahb_write(32'h8, 32'hFFFF_FFFF, 3'b010);
    @(negedge CLK);
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        rs, ry;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h14; bus.HWRITE = 1'b0; bus.HSIZE = 3'b010;
    @(negedge CLK);
    bus_idle();
    tests_run++; if (bus.HRESP !== 1'b1 || bus.HREADYOUT !== 1'b0) begin tests_failed++; $display("FAIL err_read_cycle1: got resp=%b rdy=%b exp resp=1 rdy=0", bus.HRESP, bus.HREADYOUT); end
    @(negedge CLK);
    tests_run++; if (bus.HRESP !== 1'b1 || bus.HREADYOUT !== 1'b1) begin tests_failed++; $display("FAIL err_read_cycle2: got resp=%b rdy=%b exp resp=1 rdy=1", bus.HRESP, bus.HREADYOUT); end
    @(negedge CLK);
    tests_run++; if (bus.HRESP !== 1'b0 || bus.HREADYOUT !== 1'b1) begin tests_failed++; $display("FAIL err_read_idle: got resp=%b rdy=%b exp resp=0 rdy=1", bus.HRESP, bus.HREADYOUT); end
    ahb_write(32'h0, 32'hFFFF_FFFF, 3'b000);
    tests_run++; if (bus.HRESP !== 1'b1 || bus.HREADYOUT !== 1'b0) begin tests_failed++; $display("FAIL err_byte_cycle1: got resp=%b rdy=%b exp resp=1 rdy=0", bus.HRESP, bus.HREADYOUT); end
    @(negedge CLK);
    tests_run++; if (bus.HRESP !== 1'b1 || bus.HREADYOUT !== 1'b1) begin tests_failed++; $display("FAIL err_byte_cycle2: got resp=%b rdy=%b exp resp=1 rdy=1", bus.HRESP, bus.HREADYOUT); end
    @(negedge CLK);
    ahb_read(32'h0, rd, rs, ry);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL err_byte_level_unchanged: got %h exp %h", rd, 32'h0); end
    @(negedge CLK);
    ahb_write(32'h10, 32'hFFFF_FFFF, 3'b010);
    tests_run++; if (bus.HRESP !== 1'b1 || bus.HREADYOUT !== 1'b0) begin tests_failed++; $display("FAIL err_status_write: got resp=%b rdy=%b exp resp=1 rdy=0", bus.HRESP, bus.HREADYOUT); end
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        rs, ry;
    ahb_write(32'hC, 32'h0000_A5A5, 3'b010);
    @(negedge CLK);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h18; bus.HWRITE = 1'b0; bus.HSIZE = 3'b010;
    @(negedge CLK);
    bus_idle();
    @(negedge CLK);
    ahb_read(32'hC, rd, rs, ry);
    tests_run++; if (rd !== 32'h0000_A5A5) begin tests_failed++; $display("FAIL b2b_read_after_err2: got %h exp %h", rd, 32'h0000_A5A5); end
    tests_run++; if (rs !== 1'b0 || ry !== 1'b1) begin tests_failed++; $display("FAIL b2b_okay_after_err2: got resp=%b rdy=%b exp resp=0 rdy=1", rs, ry); end
    @(negedge CLK);
    ahb_write(32'h0, 32'h0000_1234, 3'b010);
    ahb_read(32'h0, rd, rs, ry);
    tests_run++; if (rd !== 32'h0000_1234) begin tests_failed++; $display("FAIL b2b_write_then_read: got %h exp %h", rd, 32'h0000_1234); end
    @(negedge CLK);
    tests_run++; if (IRQ !== 32'h0000_0024) begin tests_failed++; $display("FAIL b2b_irq_masked_level: got %h exp %h", IRQ, 32'h0000_0024); end
  endtask

  task automatic test_reset_mid_error();
    logic [31:0] rd;
    logic        rs, ry;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h14; bus.HWRITE = 1'b0; bus.HSIZE = 3'b010;
    @(negedge CLK);
    bus_idle();
    tests_run++; if (bus.HREADYOUT !== 1'b0) begin tests_failed++; $display("FAIL rst_err_in_err1: got rdy=%b exp 0", bus.HREADYOUT); end
    RESET   = 1'b1;
    EXT_IRQ = 32'hFFFF_FFFF;
    @(negedge CLK);
    tests_run++; if (bus.HRESP !== 1'b0 || bus.HREADYOUT !== 1'b1) begin tests_failed++; $display("FAIL rst_err_abort: got resp=%b rdy=%b exp resp=0 rdy=1", bus.HRESP, bus.HREADYOUT); end
    tests_run++; if (IRQ !== 32'h0) begin tests_failed++; $display("FAIL rst_err_irq: got %h exp %h", IRQ, 32'h0); end
    @(negedge CLK);
    RESET = 1'b0;
    ahb_write(32'hC, 32'hFFFF_FFFF, 3'b010);
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge CLK);
      tests_run++; if (IRQ !== 32'h0) begin tests_failed++; $display("FAIL rst_no_pulse_cycle%0d: got %h exp %h", k, IRQ, 32'h0); end
    end
    ahb_read(32'h8, rd, rs, ry);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL rst_no_edge_logged: got %h exp %h", rd, 32'h0); end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge_set();
    test_masked_edge();
    test_ext_edge();
    test_collision();
    test_errors();
    test_back_to_back();
    test_reset_mid_error();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
